// File: rtl/fir_decim_sched.sv
// fir_decim_sched: sequencing controller for a decimating FIR stage.
// Accepts samples over a valid/ready handshake into a circular history
// buffer. On every DECIM-th accepted sample it runs one multiply-accumulate
// per cycle across all TAPS coefficients, which are fetched from an external
// combinational ROM. The result is then held on out_data until it is taken.
// Optional build macro: FIR_SCHED_ROUND_EN selects round-half-up product
// scaling. When it is undefined, products are floored by an arithmetic shift.
module fir_decim_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int TAPS       = 32,
  parameter int DECIM      = 8,
  parameter int BITS       = 10
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [DATA_WIDTH-1:0]  in_data,
  output logic [$clog2(TAPS)-1:0]       coef_addr,
  input  logic signed [DATA_WIDTH-1:0]  coef_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [DATA_WIDTH-1:0]  out_data
);

  localparam int AW = $clog2(TAPS);
  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DECIM - 1);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                        state;
  logic signed [DATA_WIDTH-1:0]  hist [TAPS];
  logic [AW-1:0]                 wr_ptr;
  logic [AW-1:0]                 tap;
  logic [CW-1:0]                 decim_cnt;
  logic signed [DATA_WIDTH-1:0]  acc;

  logic [AW-1:0]                 rd_idx;
  logic signed [DATA_WIDTH-1:0]  mac_sample;
  logic signed [DATA_WIDTH-1:0]  prod;
  logic signed [DATA_WIDTH-1:0]  acc_next;

  // Full-precision product scaled back down by BITS fraction bits and
  // truncated. Wrap-around on truncation is intentional.
  function automatic logic signed [DATA_WIDTH-1:0] scale_prod(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [2*DATA_WIDTH-1:0] full;
    full = a * b;
`ifdef FIR_SCHED_ROUND_EN
    full = full + ({{(2*DATA_WIDTH-1){1'b0}}, 1'b1} << (BITS - 1));
`endif
    return DATA_WIDTH'(full >>> BITS);
  endfunction

  // Tap 0 is the newest sample; indices wrap because TAPS is a power of two.
  always_comb begin
    rd_idx     = wr_ptr - AW'(1) - tap;
    mac_sample = hist[rd_idx];
    prod       = scale_prod(mac_sample, coef_data);
    acc_next   = acc + prod;
  end

  // Handshake and ROM address decode straight from the state register, so
  // out_ready never reaches in_ready combinationally.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == OUT);
    coef_addr = (state == MAC) ? tap : '0;
  end

  // Controller: sample intake, TAPS-cycle MAC sweep, output hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      tap       <= '0;
      decim_cnt <= '0;
      acc       <= '0;
      out_data  <= '0;
      for (int i = 0; i < TAPS; i++) hist[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            hist[wr_ptr] <= in_data;
            wr_ptr       <= wr_ptr + 1'b1;
            if (decim_cnt == LAST_CNT) begin
              decim_cnt <= '0;
              tap       <= '0;
              acc       <= '0;
              state     <= MAC;
            end else begin
              decim_cnt <= decim_cnt + 1'b1;
            end
          end
        end
        MAC: begin
          acc <= acc_next;
          tap <= tap + 1'b1;
          if (tap == LAST_TAP) begin
            out_data <= acc_next;
            state    <= OUT;
          end
        end
        OUT: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_decim_sched.sv
// Testbench for fir_decim_sched: directed vectors, scoreboard queue of
// expected outputs and a monitor that checks every output handshake.
module tb_fir_decim_sched;
  localparam int DW    = 32;
  localparam int TAPS  = 32;
  localparam int DECIM = 8;
  localparam int BITS  = 10;

`ifdef FIR_SCHED_ROUND_EN
  localparam logic signed [DW-1:0] RND_POS = 1;
  localparam logic signed [DW-1:0] RND_NEG = 0;
`else
  localparam logic signed [DW-1:0] RND_POS = 0;
  localparam logic signed [DW-1:0] RND_NEG = -1;
`endif

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic signed [DW-1:0]  in_data;
  logic [4:0]            coef_addr;
  logic signed [DW-1:0]  coef_data;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [DW-1:0]  out_data;

  logic signed [DW-1:0]  coef_rom [TAPS];
  logic signed [DW-1:0]  exp_q [$];
  logic signed [DW-1:0]  mon_exp;
  logic signed [DW-1:0]  imp_exp [5];
  int n_cmp  = 0;
  int n_fail = 0;

  fir_decim_sched #(.DATA_WIDTH(DW), .TAPS(TAPS), .DECIM(DECIM), .BITS(BITS)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clock = ~clock;

  assign coef_data = coef_rom[coef_addr];

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  // Monitor: every accepted output is compared against the scoreboard head.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: got %0d, want no output", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_data !== mon_exp) begin
          n_fail++;
          $display("FAIL out_data: got %0d, want %0d", out_data, mon_exp);
        end
      end
    end
  end

  task automatic send(input logic signed [DW-1:0] v);
    int guard;
    guard = 0;
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = v;
    while (!in_ready && guard < 1000) begin
      @(negedge clock);
      guard++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=0 after %0d cycles, want 1", guard);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(posedge clock);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d outputs pending, want 0", exp_q.size());
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int lat;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    for (int i = 0; i < TAPS; i++) coef_rom[i] = '0;
    imp_exp[0] = 1024;
    imp_exp[1] = 9216;
    imp_exp[2] = 17408;
    imp_exp[3] = 25600;
    imp_exp[4] = 0;

    repeat (2) @(posedge clock);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_coef_addr", coef_addr, 0);
    @(negedge clock);
    reset = 1'b0;

    // Ramp-up: unity coefficients, eight samples of 1.0
    for (int i = 0; i < TAPS; i++) coef_rom[i] = 1024;
    for (int i = 0; i < 7; i++) send(1024);
    check("ramp_no_early_out", out_valid, 0);
    exp_q.push_back(8192);
    send(1024);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check("ramp_latency", lat, 32);
    @(posedge clock);
    #1;

    // Backpressure: output held five cycles with the next sample waiting
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(101);
    exp_q.push_back(9000);
    send(101);
    fork
      send(555);
      begin : bp_watch
        int g;
        g = 0;
        while (!out_valid && g < 200) begin
          @(posedge clock);
          #1;
          g++;
        end
        check("bp_out_valid", out_valid, 1);
        for (int k = 0; k < 5; k++) begin
          @(negedge clock);
          check("bp_hold_data", out_data, 9000);
          check("bp_in_ready", in_ready, 0);
          check("bp_valid_held", out_valid, 1);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 7; i++) begin
      if (i == 6) exp_q.push_back(9555);
      send(0);
    end
    drain();

    // Impulse response through a ramped coefficient set
    pulse_reset();
    for (int i = 0; i < TAPS; i++) coef_rom[i] = 1024 * (i + 1);
    for (int s = 0; s < 40; s++) begin
      if (s % 8 == 7) exp_q.push_back(imp_exp[s / 8]);
      send((s == 7) ? 1024 : 0);
    end
    drain();

    // Wrap-around: only tap 0 active, output tracks newest sample
    pulse_reset();
    for (int i = 0; i < TAPS; i++) coef_rom[i] = 0;
    coef_rom[0] = 1024;
    for (int s = 1; s <= 40; s++) begin
      if (s % 8 == 0) exp_q.push_back(s);
      send(s);
    end
    drain();

    // Rounding of a half-LSB product, positive and negative
    coef_rom[0] = 512;
    for (int i = 0; i < 7; i++) send(0);
    exp_q.push_back(RND_POS);
    send(1);
    for (int i = 0; i < 7; i++) send(0);
    exp_q.push_back(RND_NEG);
    send(-1);
    drain();

    // Reset in the middle of the MAC sweep discards the partial result
    for (int i = 0; i < TAPS; i++) coef_rom[i] = 1024;
    for (int i = 0; i < 8; i++) send(1024);
    repeat (10) @(posedge clock);
    #1;
    check("mid_mac_coef_addr", coef_addr, 10);
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_coef_addr", coef_addr, 0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) send(1024);
    exp_q.push_back(8192);
    send(1024);
    drain();

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
